// File: rtl/rs_dec_pkg.sv
// Shared RS decoder constants and scheduler state encoding.
// Combinational only; no flow control.
package rs_dec_pkg;

    localparam int CW_WORDS = 24;
    localparam int MAX_CW   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rs_fifo_sched.sv
// RS codeword buffer scheduler: admits whole codewords, tracks decode status, pops decoded bursts.
// push is combinational, pop is registered (burst 1 cycle after decision); overflow drops whole codewords.
module rs_fifo_sched
    import rs_dec_pkg::*;
#(
    parameter int CW_WORDS = rs_dec_pkg::CW_WORDS,
    parameter int MAX_CW   = rs_dec_pkg::MAX_CW
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_vld,
    input  logic       in_last,
    input  logic       dec_done,
    input  logic       out_rdy,
    output logic       push_data_ena,
    output logic       pop_data_ena,
    output logic [1:0] cw_pending,
    output logic [1:0] cw_decoded,
    output logic       ovf,
    output logic       len_err,
    output logic       busy
);

    sched_state_t state_q, state_d;
    logic [4:0]   pop_cnt, pop_cnt_d;
    logic         pop_ena_d;
    logic         pop_fin;
    logic         start_ok;

    logic [4:0]   rx_cnt;
    logic         accept;
    logic         in_cw;
    logic         in_cw_d;
    logic         pend_inc;
    logic         dec_ok;
    logic [2:0]   pend_nxt;
    logic [2:0]   dec_nxt;

    assign push_data_ena = in_vld & accept;
    assign pend_inc      = push_data_ena & in_last;
    assign dec_ok        = dec_done & (cw_decoded < cw_pending);
    assign start_ok      = (cw_decoded != 2'd0) & out_rdy;
    assign busy          = (state_q != IDLE);

    assign pend_nxt = {1'b0, cw_pending} + {2'b00, pend_inc} - {2'b00, pop_fin};
    assign dec_nxt  = {1'b0, cw_decoded} + {2'b00, dec_ok}   - {2'b00, pop_fin};
    assign in_cw_d  = in_vld ? ~in_last : in_cw;

    // GAP re-evaluates the start condition itself so back-to-back bursts sit one low cycle apart.
    always_comb begin
        state_d   = state_q;
        pop_ena_d = 1'b0;
        pop_cnt_d = pop_cnt;
        pop_fin   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d   = POP;
                    pop_ena_d = 1'b1;
                    pop_cnt_d = 5'd0;
                end
            end
            POP: begin
                if (pop_cnt == 5'(CW_WORDS - 1)) begin
                    pop_fin   = 1'b1;
                    state_d   = GAP;
                    pop_cnt_d = 5'd0;
                end else begin
                    pop_ena_d = 1'b1;
                    pop_cnt_d = pop_cnt + 5'd1;
                end
            end
            GAP: begin
                if (start_ok) begin
                    state_d   = POP;
                    pop_ena_d = 1'b1;
                    pop_cnt_d = 5'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            pop_cnt      <= 5'd0;
            pop_data_ena <= 1'b0;
        end else begin
            state_q      <= state_d;
            pop_cnt      <= pop_cnt_d;
            pop_data_ena <= pop_ena_d;
        end
    end

    // Admission is decided from the capacity seen just before a codeword's first word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_cnt     <= 5'd0;
            accept     <= 1'b0;
            in_cw      <= 1'b0;
            cw_pending <= 2'd0;
            cw_decoded <= 2'd0;
            ovf        <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            in_cw      <= in_cw_d;
            cw_pending <= pend_nxt[1:0];
            cw_decoded <= dec_nxt[1:0];
            if (!in_cw_d) begin
                accept <= (pend_nxt < 3'(MAX_CW));
            end
            if (in_vld && !in_cw && !accept) begin
                ovf <= 1'b1;
            end
            if (push_data_ena && !in_last && rx_cnt != 5'h1f) begin
                rx_cnt <= rx_cnt + 5'd1;
            end
            if (pend_inc) begin
                rx_cnt <= 5'd0;
                if (rx_cnt != 5'(CW_WORDS)) begin
                    len_err <= 1'b1;
                end
            end
            if (dec_done && !dec_ok) begin
                len_err <= 1'b1;
            end
        end
    end

endmodule
